// File: rtl/jogo_pkg.sv
// Shared play-field definitions for the game blocks.
// Holds the FSM state encoding used by the shot engines, the vertical
// play-field limits, the ship geometry and the shot colour.
package jogo_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    LANCA  = 2'd1,
    VOO    = 2'd2,
    FIM    = 2'd3
  } estado_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } cor_t;

  // Vertical limits of the play field
  localparam int unsigned CAMPO_TOPO_Y  = 40;
  localparam int unsigned NAVE_TOPO_Y   = 490;

  // Ship and shot geometry
  localparam int unsigned NAVE_LARG     = 22;
  localparam int unsigned TIRO_LARG     = 2;
  localparam int unsigned TIRO_ALT      = 8;
  localparam int unsigned TIRO_INICIO_Y = NAVE_TOPO_Y - TIRO_ALT;
  localparam int unsigned TIRO_X_OFFSET = (NAVE_LARG - TIRO_LARG) / 2;

  localparam cor_t COR_TIRO = '{r: 8'hFF, g: 8'hFF, b: 8'h00};

endpackage

// File: rtl/sprite_retangulo.sv
// Registered rectangle hit test for a sprite.
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   ativo_i              : sprite visible
//   pos_x_i, pos_y_i     : sprite top-left corner
//   scan_x_i, scan_y_i   : current VGA scan point
//   r_o, g_o, b_o        : COR when the scan point is inside
//                          [x, x+LARG) x [y, y+ALT), else black; one cycle latency
module sprite_retangulo
  import jogo_pkg::*;
#(
  parameter int unsigned LARG = TIRO_LARG,
  parameter int unsigned ALT  = TIRO_ALT,
  parameter cor_t        COR  = COR_TIRO
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ativo_i,
  input  logic [10:0] pos_x_i,
  input  logic [10:0] pos_y_i,
  input  logic [9:0]  scan_x_i,
  input  logic [9:0]  scan_y_i,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o
);

  // One extra bit so the far edge cannot wrap at the top of the 11-bit range
  logic [11:0] x0, x1, y0, y1, sx, sy;
  logic        dentro;
  cor_t        cor_d, cor_q;

  always_comb begin
    x0     = {1'b0, pos_x_i};
    y0     = {1'b0, pos_y_i};
    x1     = x0 + 12'(LARG);
    y1     = y0 + 12'(ALT);
    sx     = {2'b00, scan_x_i};
    sy     = {2'b00, scan_y_i};
    dentro = ativo_i && (sx >= x0) && (sx < x1) && (sy >= y0) && (sy < y1);
    cor_d  = dentro ? COR : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cor_q <= '0;
    end else begin
      cor_q <= cor_d;
    end
  end

  assign r_o = cor_q.r;
  assign g_o = cor_q.g;
  assign b_o = cor_q.b;

endmodule

// File: rtl/municao_jogador.sv
// Player shot engine.
// Launches one projectile from the ship nose on a rising edge of the fire
// request, moves it up STEP_PX pixels every STEP_DELAY cycles, and retires it
// at the top of the field or on a hit acknowledge.
// Ports:
//   clk, reset (sync, active low)
//   tiro_ativo_jogador[0] : fire request level (bit 1 unused)
//   posX_Nave             : ship left X, latched at launch
//   acerto                : hit acknowledge, retires the shot while in flight
//   h_counter, v_counter  : VGA scan point
//   posX_Municao, posY_Municao, municao_ativa : shot state (0 when idle)
//   R, G, B               : shot pixel colour, registered
module municao_jogador
  import jogo_pkg::*;
#(
  parameter int unsigned START_Y    = TIRO_INICIO_Y,
  parameter int unsigned TOP_Y      = CAMPO_TOPO_Y,
  parameter int unsigned X_OFFSET   = TIRO_X_OFFSET,
  parameter int unsigned STEP_DELAY = 100000,
  parameter int unsigned STEP_PX    = 4,
  parameter int unsigned LARG       = TIRO_LARG,
  parameter int unsigned ALT        = TIRO_ALT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  tiro_ativo_jogador,
  input  logic [10:0] posX_Nave,
  input  logic        acerto,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  output logic [10:0] posX_Municao,
  output logic [10:0] posY_Municao,
  output logic        municao_ativa,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);

  localparam int unsigned CW      = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
  localparam logic [10:0] LIMITE_Y = 11'(TOP_Y + STEP_PX);

  estado_t       estado_q, estado_d;
  logic          fogo_q;
  logic [10:0]   x_q, x_d, y_q, y_d;
  logic          ativa_q, ativa_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evento_fogo, passo;
  logic          unused_tiro;

  assign unused_tiro = tiro_ativo_jogador[1];
  assign evento_fogo = tiro_ativo_jogador[0] & ~fogo_q;
  assign passo       = (cnt_q == CW'(STEP_DELAY - 1));

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      fogo_q   <= tiro_ativo_jogador[0];
      x_q      <= '0;
      y_q      <= '0;
      ativa_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      fogo_q   <= tiro_ativo_jogador[0];
      x_q      <= x_d;
      y_q      <= y_d;
      ativa_q  <= ativa_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO: if (evento_fogo) estado_d = LANCA;
      LANCA:  estado_d = VOO;
      VOO:    if (acerto || (passo && (y_q < LIMITE_Y))) estado_d = FIM;
      FIM:    estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // Datapath updates; the retire test is done before the subtraction so Y
  // never wraps below zero.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    ativa_d = ativa_q;
    cnt_d   = cnt_q;
    case (estado_q)
      LANCA: begin
        x_d     = posX_Nave + 11'(X_OFFSET);
        y_d     = 11'(START_Y);
        ativa_d = 1'b1;
        cnt_d   = '0;
      end
      VOO: begin
        if (!acerto) begin
          if (passo) begin
            cnt_d = '0;
            if (y_q >= LIMITE_Y) y_d = y_q - 11'(STEP_PX);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FIM: begin
        x_d     = '0;
        y_d     = '0;
        ativa_d = 1'b0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  assign posX_Municao  = x_q;
  assign posY_Municao  = y_q;
  assign municao_ativa = ativa_q;

  sprite_retangulo #(
    .LARG (LARG),
    .ALT  (ALT),
    .COR  (COR_TIRO)
  ) u_sprite (
    .clk_i    (clk),
    .rst_ni   (reset),
    .ativo_i  (ativa_q),
    .pos_x_i  (x_q),
    .pos_y_i  (y_q),
    .scan_x_i (h_counter),
    .scan_y_i (v_counter),
    .r_o      (R),
    .g_o      (G),
    .b_o      (B)
  );

endmodule
